frequency_to_ascii: RTL and testbench



---
 rtl/frequency_to_ascii.sv | 171 +++++++++++++++++
 tb/tb_frequency_to_ascii.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_to_ascii.sv
// Converts a captured 32-bit frequency word to decimal via sequential double-dabble
// and streams it as a fixed-format ASCII line over a valid/ready byte handshake.
module frequency_to_ascii #(
   parameter int unsigned FRACTION_DIGITS     = 4,
   parameter bit          BLANK_LEADING_ZEROS = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] frequency,
   input  logic        valid,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy,
   output logic        dropped
);

   localparam int unsigned FREQ_W   = 32;
   localparam int unsigned DIGITS   = 10;
   localparam int unsigned BCD_W    = 4 * DIGITS;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned NUM_INT  = DIGITS - FRACTION_DIGITS;
   localparam int unsigned HAS_DOT  = (FRACTION_DIGITS > 0) ? 1 : 0;
   localparam int unsigned LEN      = DIGITS + HAS_DOT + 2;
   localparam int unsigned FRAC_END = DIGITS + HAS_DOT;

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT} state_t;

   state_t             r_state,   w_state_nxt;
   logic [FREQ_W-1:0]  r_shift,   w_shift_nxt;
   logic [BCD_W-1:0]   r_bcd,     w_bcd_nxt;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx,     w_idx_nxt;
   logic               r_blank,   w_blank_nxt;
   logic [7:0]         r_byte,    w_byte_nxt;
   logic               r_bvalid,  w_bvalid_nxt;
   logic               r_busy,    w_busy_nxt;
   logic               r_dropped, w_dropped_nxt;

   logic [BCD_W-1:0]   w_adj;
   logic [IDX_W-1:0]   w_pos;
   logic [3:0]         w_nib;
   logic               w_is_int;
   logic               w_is_digit;
   logic [7:0]         w_char;
   logic               w_char_blank;

   // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Character for the byte index about to be loaded; digit 9 is the most significant.
   always_comb begin
      w_is_int     = 1'b0;
      w_is_digit   = 1'b0;
      w_pos        = '0;
      w_char       = 8'h0A;
      w_char_blank = r_blank;
      if (r_idx < IDX_W'(NUM_INT)) begin
         w_is_int   = 1'b1;
         w_is_digit = 1'b1;
         w_pos      = IDX_W'(DIGITS - 1) - r_idx;
      end else if ((HAS_DOT != 0) && (r_idx == IDX_W'(NUM_INT))) begin
         w_char = 8'h2E;
      end else if (r_idx < IDX_W'(FRAC_END)) begin
         w_is_digit = 1'b1;
         w_pos      = IDX_W'(DIGITS) - r_idx;
      end else if (r_idx == IDX_W'(LEN - 2)) begin
         w_char = 8'h0D;
      end
      w_nib = 4'(r_bcd >> {w_pos, 2'b00});
      if (w_is_digit) begin
         w_char = 8'h30 | {4'h0, w_nib};
      end
      if (w_is_int && BLANK_LEADING_ZEROS && r_blank && (w_nib == 4'd0) &&
          (r_idx != IDX_W'(NUM_INT - 1))) begin
         w_char = 8'h20;
      end
      if (w_is_int && (w_nib != 4'd0)) begin
         w_char_blank = 1'b0;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bcd_nxt     = r_bcd;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_blank_nxt   = r_blank;
      w_byte_nxt    = r_byte;
      w_bvalid_nxt  = r_bvalid;
      w_busy_nxt    = r_busy;
      w_dropped_nxt = valid & r_busy;
      unique case (r_state)
         S_IDLE: begin
            if (valid) begin
               w_shift_nxt = frequency;
               w_bcd_nxt   = '0;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_blank_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_CONVERT;
            end
         end
         S_CONVERT: begin
            {w_bcd_nxt, w_shift_nxt} = {w_adj[BCD_W-2:0], r_shift, 1'b0};
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(31)) begin
               w_state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (!r_bvalid || byte_ready) begin
               if (r_bvalid && (r_idx == IDX_W'(LEN))) begin
                  w_bvalid_nxt = 1'b0;
                  w_busy_nxt   = 1'b0;
                  w_state_nxt  = S_IDLE;
               end else begin
                  w_byte_nxt   = w_char;
                  w_bvalid_nxt = 1'b1;
                  w_blank_nxt  = w_char_blank;
                  w_idx_nxt    = r_idx + IDX_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_blank   <= 1'b0;
         r_byte    <= 8'h00;
         r_bvalid  <= 1'b0;
         r_busy    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bcd     <= w_bcd_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_blank   <= w_blank_nxt;
         r_byte    <= w_byte_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_busy    <= w_busy_nxt;
         r_dropped <= w_dropped_nxt;
      end
   end

   assign byte_out   = r_byte;
   assign byte_valid = r_bvalid;
   assign busy       = r_busy;
   assign dropped    = r_dropped;

endmodule

// File: tb/tb_frequency_to_ascii.sv
// Scoreboard bench for frequency_to_ascii: three parameter variants share stimulus,
// each with its own expected-byte queue filled from a decimal-string reference model.
module tb_frequency_to_ascii;

   localparam int unsigned NDUT = 3;

   logic        clock;
   logic        reset_n;
   logic [31:0] frequency;
   logic        valid;
   logic        byte_ready;
   bit          rand_rdy;

   logic [7:0] bo0, bo1, bo2;
   logic       bv0, bv1, bv2, bz0, bz1, bz2, dr0, dr1, dr2;
   logic [7:0] bo [NDUT];
   logic       bv [NDUT];
   logic       bz [NDUT];
   logic       dr [NDUT];

   assign bo[0] = bo0; assign bo[1] = bo1; assign bo[2] = bo2;
   assign bv[0] = bv0; assign bv[1] = bv1; assign bv[2] = bv2;
   assign bz[0] = bz0; assign bz[1] = bz1; assign bz[2] = bz2;
   assign dr[0] = dr0; assign dr[1] = dr1; assign dr[2] = dr2;

   frequency_to_ascii #(.FRACTION_DIGITS(4), .BLANK_LEADING_ZEROS(1'b1)) u_dut_std (
      .clock(clock), .reset_n(reset_n), .frequency(frequency), .valid(valid),
      .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready), .busy(bz0), .dropped(dr0));
   frequency_to_ascii #(.FRACTION_DIGITS(0), .BLANK_LEADING_ZEROS(1'b1)) u_dut_int (
      .clock(clock), .reset_n(reset_n), .frequency(frequency), .valid(valid),
      .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready), .busy(bz1), .dropped(dr1));
   frequency_to_ascii #(.FRACTION_DIGITS(4), .BLANK_LEADING_ZEROS(1'b0)) u_dut_nob (
      .clock(clock), .reset_n(reset_n), .frequency(frequency), .valid(valid),
      .byte_out(bo2), .byte_valid(bv2), .byte_ready(byte_ready), .busy(bz2), .dropped(dr2));

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q [NDUT][$];
   int         drop_cnt [NDUT];
   int         acc_cnt [NDUT];
   bit         stalled [NDUT];
   logic [7:0] held [NDUT];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: format the word as decimal text for each variant and queue the bytes.
   task automatic push_line(input logic [31:0] f);
      int     d [10];
      longint v;
      int     fd, ni;
      bit     blank, lead;
      for (int k = 0; k < int'(NDUT); k++) begin
         fd    = (k == 1) ? 0 : 4;
         blank = (k != 2);
         ni    = 10 - fd;
         v     = longint'(f);
         for (int i = 9; i >= 0; i--) begin
            d[i] = int'(v % 10);
            v    = v / 10;
         end
         lead = 1'b1;
         for (int i = 0; i < ni; i++) begin
            if (d[i] != 0) lead = 1'b0;
            if (blank && lead && i < ni - 1) exp_q[k].push_back(8'h20);
            else exp_q[k].push_back(8'(48 + d[i]));
         end
         if (fd > 0) begin
            exp_q[k].push_back(8'h2E);
            for (int i = ni; i < 10; i++) exp_q[k].push_back(8'(48 + d[i]));
         end
         exp_q[k].push_back(8'h0D);
         exp_q[k].push_back(8'h0A);
      end
   endtask

   // Monitor: pop on each accepted byte and hold-check stalled bytes.
   always @(negedge clock) begin
      for (int k = 0; k < int'(NDUT); k++) begin
         if (!reset_n) begin
            stalled[k] = 1'b0;
         end else begin
            if (dr[k]) drop_cnt[k]++;
            if (stalled[k]) begin
               chk($sformatf("hold_valid[%0d]", k), longint'(bv[k]), 1);
               chk($sformatf("hold_byte[%0d]", k), longint'(bo[k]), longint'(held[k]));
            end
            if (bv[k] && byte_ready) begin
               stalled[k] = 1'b0;
               acc_cnt[k]++;
               if (exp_q[k].size() == 0) begin
                  chk($sformatf("unexpected_byte[%0d]", k), longint'(bo[k]), -1);
               end else begin
                  chk($sformatf("byte[%0d]", k), longint'(bo[k]), longint'(exp_q[k].pop_front()));
               end
            end else if (bv[k]) begin
               stalled[k] = 1'b1;
               held[k]    = bo[k];
            end else begin
               stalled[k] = 1'b0;
            end
         end
      end
   end

   initial begin
      byte_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic issue(input logic [31:0] f, input bit keep);
      @(posedge clock);
      #1;
      frequency = f;
      valid     = 1'b1;
      if (keep) push_line(f);
      @(posedge clock);
      #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bz[0] || bz[1] || bz[2]) && n < 3000) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("idle_timeout", longint'(n >= 3000), 0);
      chk("valid_low_at_idle", longint'(bv[0]), 0);
      for (int k = 0; k < int'(NDUT); k++)
         chk($sformatf("missing_bytes[%0d]", k), longint'(exp_q[k].size()), 0);
   endtask

   initial begin
      int          n;
      int          base;
      int          d0 [NDUT];
      logic [31:0] f;
      reset_n   = 1'b0;
      valid     = 1'b0;
      frequency = '0;
      rand_rdy  = 1'b0;
      #2;
      for (int k = 0; k < int'(NDUT); k++) begin
         chk($sformatf("rst_byte_out[%0d]", k), longint'(bo[k]), 0);
         chk($sformatf("rst_byte_valid[%0d]", k), longint'(bv[k]), 0);
         chk($sformatf("rst_busy[%0d]", k), longint'(bz[k]), 0);
         chk($sformatf("rst_dropped[%0d]", k), longint'(dr[k]), 0);
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      issue(32'd2500000, 1'b1);
      chk("busy_after_capture", longint'(bz[0]), 1);
      n = 0;
      while (!bv[0] && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("first_byte_latency", n, 33);
      wait_idle();

      issue(32'd0, 1'b1);          wait_idle();
      issue(32'hFFFF_FFFF, 1'b1);  wait_idle();
      issue(32'd42, 1'b1);         wait_idle();

      rand_rdy = 1'b1;
      issue(32'd12345, 1'b1);
      wait_idle();
      for (int t = 0; t < 6; t++) begin
         f = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 99999));
         issue(f, 1'b1);
         wait_idle();
      end
      rand_rdy = 1'b0;

      for (int k = 0; k < int'(NDUT); k++) d0[k] = drop_cnt[k];
      issue(32'd2500000, 1'b1);
      repeat (10) @(posedge clock);
      issue(32'd7, 1'b0);
      n = 0;
      while (!bv[0] && n < 60) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("overrun_emit_timeout", longint'(n >= 60), 0);
      repeat (2) @(posedge clock);
      issue(32'd7, 1'b0);
      wait_idle();
      for (int k = 0; k < int'(NDUT); k++)
         chk($sformatf("dropped_pulses[%0d]", k), drop_cnt[k] - d0[k], 2);
      issue(32'd7, 1'b1);
      wait_idle();

      base = acc_cnt[0];
      issue(32'd2500000, 1'b1);
      n = 0;
      while (acc_cnt[0] < base + 5 && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("reset_wait_timeout", longint'(n >= 100), 0);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < int'(NDUT); k++) begin
         chk($sformatf("midreset_valid[%0d]", k), longint'(bv[k]), 0);
         chk($sformatf("midreset_busy[%0d]", k), longint'(bz[k]), 0);
         exp_q[k].delete();
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      issue(32'd100, 1'b1);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
